qcw_zc_tracker: RTL and testbench
=================================

Name: qcw_zc_tracker

Overview:
- Measures the resonant period of the QCW tank from the zero-cross comparator on the primary current transformer.
- Produces the period, phase_shift and latch inputs consumed by qcw_osc, closing the loop: qcw_osc drives the gate-drive transformers, and this block reads the resulting tank current back.
- Runs entirely in the clk_logic domain; the comparator input is asynchronous.

Parameters:
- CNT_W, 20, width of the interval counter in clk_logic cycles.
- SERDES_SHIFT, 2, log2(clk_serdes/clk_logic); converts logic-cycle counts to serdes-bit units.
- MIN_CNT, 16, shortest valid interval in clk_logic cycles; shorter intervals are treated as glitches.
- MAX_CNT, 4096, longest valid interval in clk_logic cycles.
- LOCK_COUNT, 4, number of consecutive valid intervals required to lock.
- TIMEOUT_CNT, 8192, number of cycles without an edge that raises a fault; must be greater than MAX_CNT.

Ports:
- clk_logic  in  1  logic clock, the only clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  tracking enable.
- zc_in  in  1  asynchronous zero-cross comparator output.
- default_period  in  24  open-loop period in serdes-bit units.
- delay_comp  in  16  loop-delay compensation subtracted from phase, in serdes bits.
- period  out  24  period to qcw_osc, in serdes bits.
- phase_shift  out  24  phase shift to qcw_osc, in serdes bits.
- latch  out  1  one-cycle pulse when period or phase_shift change.
- locked  out  1  high while in TRACK.
- fault  out  1  sticky zero-cross loss flag.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; period=0, phase_shift=0, latch=0, locked=0, fault=0; counter and run count cleared; synchronizer flops cleared.
- Input path: zc_in passes through a 2-flop synchronizer, then an edge register. A rising edge is detected 3 cycles after zc_in rises. Only rising edges are used.
- Interval counter:
  - On a detected edge the counter loads 1; otherwise it increments.
  - It saturates at TIMEOUT_CNT.
  - The measured interval N is the counter value sampled at an edge, i.e. the number of cycles between edges.
- Arithmetic:
  - meas = N << SERDES_SHIFT, zero-extended or truncated to 24 bits.
  - phase = (meas >> 2) - delay_comp, clamped to 0 on underflow.
- Output registers: period and phase_shift update one cycle after the edge. latch pulses high in that same cycle only.
- IDLE:
  - Entered whenever enable=0, from any state, on the next cycle.
  - period=default_period, phase_shift=(default_period>>2)-delay_comp (clamped), updated every cycle.
  - latch=0, locked=0, fault cleared.
  - On enable=1: emit one latch pulse carrying the default values, clear the run count, go to ACQUIRE.
- ACQUIRE:
  - The first edge after entry only restarts the counter; its interval is discarded.
  - Each later edge with MIN_CNT<=N<=MAX_CNT increments the run count. Any other interval clears the run count; no latch is issued.
  - When the run count reaches LOCK_COUNT: go to TRACK, load outputs from that interval, pulse latch, locked=1.
- TRACK:
  - An edge with N<MIN_CNT is ignored: it is a glitch, so the counter is not reset and outputs are unchanged.
  - An edge with MIN_CNT<=N<=MAX_CNT updates the outputs and pulses latch.
  - An edge with N>MAX_CNT: return to ACQUIRE, locked=0, restore default outputs, pulse latch.
- FAULT:
  - Entered from ACQUIRE or TRACK when the counter reaches TIMEOUT_CNT.
  - On entry: fault=1, locked=0, default outputs, one latch pulse.
  - Edges are ignored; exit is only via enable=0 to IDLE.
- Simultaneous events:
  - enable=0 beats every other event: no latch is issued in that cycle.
  - An edge in the same cycle as the timeout is processed as an edge; no fault is raised.
- latch never pulses on two consecutive cycles, except when an IDLE-exit pulse is followed by a state-entry pulse; that case cannot occur because ACQUIRE needs at least 2 edges before it can lock.

Optional Feature:
- Macro: QCW_PERIOD_AVG_EN.
- Defined:
  - In TRACK the period output is an IIR average over meas: avg <= avg + ((meas - avg) >>> 2), computed with signed 25-bit arithmetic.
  - avg is seeded with the locking interval's meas on TRACK entry.
  - phase_shift is derived from avg.
  - Output latency is unchanged at 1 cycle.
- Undefined: period=meas exactly as specified above, with no averaging registers.

Test Plan:
- Setup: default_period=777, delay_comp=10, enable=1, no zc_in edges → latch pulse with period=777, phase_shift=184; after TIMEOUT_CNT cycles → fault=1 plus one latch pulse; drop enable → fault=0.
- zc_in square wave, 200-cycle period → locked rises after the 5th edge; period=800, phase_shift=190; latch pulses once per edge thereafter.
- While locked at 200 cycles, inject a 3-cycle glitch pulse mid-cycle → no latch; period stays 800; the next true edge reports 800.
- While locked, stop edges for 5000 cycles and then resume → return to ACQUIRE at the late edge, locked=0, period=777; relock after 4 valid intervals.
- Pull reset_n low mid-TRACK → all outputs 0 immediately; after release and enable=1 → defaults latched, then reacquire.
- With QCW_PERIOD_AVG_EN defined: lock at 200 cycles, then step to 220 cycles → period goes 800, 820, 835, 846... converging to 880.

Source files
------------

// File: rtl/qcw_zc_tracker.sv
// -----------------------------------------------------------------------------
// qcw_zc_tracker
//
// Measures the resonant period of the QCW tank from the primary-CT zero-cross
// comparator. It supplies qcw_osc with period, phase_shift and a latch strobe,
// which closes the drive loop. Everything runs on clk_logic. zc_in is
// asynchronous and is synchronised on the way in.
//
// Ports:
//   clk_logic       logic clock (only clock)
//   reset_n         asynchronous active-low reset
//   enable          tracking enable; low forces IDLE
//   zc_in           asynchronous zero-cross comparator output
//   default_period  open-loop period, serdes-bit units
//   delay_comp      loop-delay compensation subtracted from phase, serdes bits
//   period          period to qcw_osc, serdes bits
//   phase_shift     phase shift to qcw_osc, serdes bits
//   latch           one-cycle strobe when period/phase_shift change
//   locked          high while in TRACK
//   fault           sticky zero-cross loss flag (cleared in IDLE)
//
// Optional build macro:
//   QCW_PERIOD_AVG_EN  In TRACK, period is a 1/4-gain IIR average of the
//                      measured interval rather than the raw measurement.
// -----------------------------------------------------------------------------
module qcw_zc_tracker #(
    parameter int CNT_W        = 20,
    parameter int SERDES_SHIFT = 2,
    parameter int MIN_CNT      = 16,
    parameter int MAX_CNT      = 4096,
    parameter int LOCK_COUNT   = 4,
    parameter int TIMEOUT_CNT  = 8192
) (
    input  logic        clk_logic,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        zc_in,
    input  logic [23:0] default_period,
    input  logic [15:0] delay_comp,
    output logic [23:0] period,
    output logic [23:0] phase_shift,
    output logic        latch,
    output logic        locked,
    output logic        fault
);

    localparam int MW    = CNT_W + SERDES_SHIFT;
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] MIN_N     = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] MAX_N     = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(TIMEOUT_CNT);
    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, FAULT} state_t;

    state_t             state, state_nxt;
    logic               zc_s1, zc_s2, zc_s3;
    logic               edge_det;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RUN_W-1:0]   run, run_nxt;
    logic               first_edge, first_edge_nxt;
    logic [23:0]        period_nxt, phase_nxt;
    logic               latch_nxt;
    logic [MW-1:0]      meas_wide;
    logic [23:0]        meas;
    logic [23:0]        track_period;
    logic [23:0]        dflt_phase;
    logic               in_range, too_short, glitch, timeout;

    // Quarter period minus the loop-delay compensation, floored at zero.
    function automatic logic [23:0] phase_of(input logic [23:0] p,
                                             input logic [15:0] dc);
        logic [23:0] q;
        q = p >> 2;
        if (q < {8'd0, dc})
            return '0;
        return q - {8'd0, dc};
    endfunction

    assign edge_det   = zc_s2 & ~zc_s3;
    assign meas_wide  = MW'(cnt) << SERDES_SHIFT;
    assign meas       = 24'(meas_wide);
    assign dflt_phase = phase_of(default_period, delay_comp);
    assign too_short  = (cnt < MIN_N);
    assign in_range   = !too_short && (cnt <= MAX_N);
    // In TRACK a short interval is a comparator glitch: the counter keeps
    // running so the next true edge still measures the full period.
    assign glitch     = (state == TRACK) && edge_det && too_short;
    // An edge landing on the timeout cycle wins over the timeout.
    assign timeout    = (cnt == TIMEOUT_N) && !edge_det;

`ifdef QCW_PERIOD_AVG_EN
    // While in TRACK the period register already holds the running average
    // (seeded with the locking measurement), so it doubles as the IIR state.
    logic signed [24:0] avg_diff, avg_sum;
    assign avg_diff     = $signed({1'b0, meas}) - $signed({1'b0, period});
    assign avg_sum      = $signed({1'b0, period}) + (avg_diff >>> 2);
    assign track_period = avg_sum[23:0];
`else
    assign track_period = meas;
`endif

    always_comb begin
        cnt_nxt = cnt;
        if (state == IDLE)
            cnt_nxt = '0;
        else if (edge_det && !glitch)
            cnt_nxt = CNT_W'(1);
        else if (cnt != TIMEOUT_N)
            cnt_nxt = cnt + 1'b1;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt      = state;
        run_nxt        = run;
        first_edge_nxt = first_edge;
        period_nxt     = period;
        phase_nxt      = phase_shift;
        latch_nxt      = 1'b0;

        if (!enable) begin
            state_nxt  = IDLE;
            period_nxt = default_period;
            phase_nxt  = dflt_phase;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt      = ACQUIRE;
                    run_nxt        = '0;
                    first_edge_nxt = 1'b1;
                    period_nxt     = default_period;
                    phase_nxt      = dflt_phase;
                    latch_nxt      = 1'b1;
                end
                ACQUIRE: begin
                    if (edge_det) begin
                        if (first_edge) begin
                            first_edge_nxt = 1'b0;
                        end else if (in_range) begin
                            if (run == RUN_LAST) begin
                                state_nxt  = TRACK;
                                run_nxt    = '0;
                                period_nxt = meas;
                                phase_nxt  = phase_of(meas, delay_comp);
                                latch_nxt  = 1'b1;
                            end else begin
                                run_nxt = run + 1'b1;
                            end
                        end else begin
                            run_nxt = '0;
                        end
                    end else if (timeout) begin
                        state_nxt  = FAULT;
                        period_nxt = default_period;
                        phase_nxt  = dflt_phase;
                        latch_nxt  = 1'b1;
                    end
                end
                TRACK: begin
                    if (edge_det) begin
                        if (in_range) begin
                            period_nxt = track_period;
                            phase_nxt  = phase_of(track_period, delay_comp);
                            latch_nxt  = 1'b1;
                        end else if (!too_short) begin
                            state_nxt      = ACQUIRE;
                            run_nxt        = '0;
                            first_edge_nxt = 1'b1;
                            period_nxt     = default_period;
                            phase_nxt      = dflt_phase;
                            latch_nxt      = 1'b1;
                        end
                    end else if (timeout) begin
                        state_nxt  = FAULT;
                        period_nxt = default_period;
                        phase_nxt  = dflt_phase;
                        latch_nxt  = 1'b1;
                    end
                end
                FAULT: begin
                    // Held until enable drops.
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_logic or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            zc_s1       <= 1'b0;
            zc_s2       <= 1'b0;
            zc_s3       <= 1'b0;
            cnt         <= '0;
            run         <= '0;
            first_edge  <= 1'b0;
            period      <= '0;
            phase_shift <= '0;
            latch       <= 1'b0;
            locked      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples the
            // pre-edge values regardless of statement order.
            state       <= state_nxt;
            zc_s1       <= zc_in;
            zc_s2       <= zc_s1;
            zc_s3       <= zc_s2;
            cnt         <= cnt_nxt;
            run         <= run_nxt;
            first_edge  <= first_edge_nxt;
            period      <= period_nxt;
            phase_shift <= phase_nxt;
            latch       <= latch_nxt;
            locked      <= (state_nxt == TRACK);
            fault       <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_qcw_zc_tracker.sv
// -----------------------------------------------------------------------------
// tb_qcw_zc_tracker
//
// Self-checking bench for qcw_zc_tracker. A behavioural model tracks zero-cross
// rising edges by bench time and applies the tracking rules to the
// rise-to-rise intervals. The bench compares its predicted outputs and latch
// count against the DUT a few cycles after every rising edge, and also after
// enable changes, timeout and reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qcw_zc_tracker;

    localparam int MIN_CNT     = 16;
    localparam int MAX_CNT     = 4096;
    localparam int LOCK_COUNT  = 4;
    localparam int TIMEOUT_CNT = 8192;
    localparam int CHK         = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ACQ   = 1;
    localparam int M_TRK   = 2;
    localparam int M_FAULT = 3;

    logic        clk_logic = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        zc_in = 1'b0;
    logic [23:0] default_period = '0;
    logic [15:0] delay_comp = '0;
    logic [23:0] period, phase_shift;
    logic        latch, locked, fault;

    qcw_zc_tracker dut (
        .clk_logic      (clk_logic),
        .reset_n        (reset_n),
        .enable         (enable),
        .zc_in          (zc_in),
        .default_period (default_period),
        .delay_comp     (delay_comp),
        .period         (period),
        .phase_shift    (phase_shift),
        .latch          (latch),
        .locked         (locked),
        .fault          (fault)
    );

    always #5 clk_logic = ~clk_logic;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle counter and latch monitor.
    longint cyc = 0;
    always @(posedge clk_logic) cyc <= cyc + 1;

    int   lat_cnt  = 0;
    int   lat_seen = 0;
    int   dbl      = 0;
    logic lat_prev = 1'b0;
    always @(negedge clk_logic) begin
        if (latch === 1'b1) begin
            lat_cnt++;
            if (lat_prev) dbl++;
        end
        lat_prev = (latch === 1'b1);
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    int     m_mode = M_IDLE;
    longint m_last = 0;
    bit     m_first = 1'b0;
    int     m_run = 0;
    longint m_period = 0;
    longint m_phase = 0;
    bit     m_locked = 1'b0;
    bit     m_fault = 1'b0;
    int     m_lat_pend = 0;

    function automatic longint meas_of(input longint n);
        return (n * 4) % (longint'(1) << 24);
    endfunction

    function automatic longint phase_of(input longint p);
        longint q, dc;
        q  = p / 4;
        dc = longint'(delay_comp);
        return (q > dc) ? q - dc : 0;
    endfunction

    function automatic void model_defaults();
        m_period = longint'(default_period);
        m_phase  = phase_of(m_period);
    endfunction

    function automatic void model_set(input longint n, input bit seed);
        longint v;
        v = meas_of(n);
`ifdef QCW_PERIOD_AVG_EN
        if (!seed) begin
            longint d;
            d = v - m_period;
            v = m_period + ((d >= 0) ? d / 4 : -((3 - d) / 4));
        end
`endif
        m_period = v;
        m_phase  = phase_of(v);
    endfunction

    function automatic void model_enable();
        m_mode   = M_ACQ;
        m_first  = 1'b1;
        m_run    = 0;
        m_locked = 1'b0;
        m_fault  = 1'b0;
        model_defaults();
        m_lat_pend++;
    endfunction

    function automatic void model_disable();
        m_mode   = M_IDLE;
        m_locked = 1'b0;
        m_fault  = 1'b0;
        model_defaults();
    endfunction

    function automatic void model_rise(input longint t);
        longint n;
        n = t - m_last;
        if (n > TIMEOUT_CNT) n = TIMEOUT_CNT;
        case (m_mode)
            M_ACQ: begin
                m_last = t;
                if (m_first) begin
                    m_first = 1'b0;
                end else if (n >= MIN_CNT && n <= MAX_CNT) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) begin
                        m_mode   = M_TRK;
                        m_locked = 1'b1;
                        model_set(n, 1'b1);
                        m_lat_pend++;
                    end
                end else begin
                    m_run = 0;
                end
            end
            M_TRK: begin
                if (n >= MIN_CNT) begin
                    m_last = t;
                    if (n <= MAX_CNT) begin
                        model_set(n, 1'b0);
                    end else begin
                        m_mode   = M_ACQ;
                        m_first  = 1'b1;
                        m_run    = 0;
                        m_locked = 1'b0;
                        model_defaults();
                    end
                    m_lat_pend++;
                end
            end
            default: ;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic check_outputs(input string tag);
        check({tag, ".latches"}, 64'(lat_cnt - lat_seen), 64'(m_lat_pend));
        lat_seen   = lat_cnt;
        m_lat_pend = 0;
        check({tag, ".period"}, 64'(period), 64'(m_period));
        check({tag, ".phase"}, 64'(phase_shift), 64'(m_phase));
        check({tag, ".locked"}, 64'(locked), 64'(m_locked));
        check({tag, ".fault"}, 64'(fault), 64'(m_fault));
    endtask

    // One zero-cross cycle: a rising edge, hi cycles high, lo cycles low.
    task automatic pulse(input string tag, input int hi, input int lo);
        for (int c = 0; c < hi + lo; c++) begin
            zc_in = (c < hi);
            if (c == 0) model_rise(cyc);
            @(negedge clk_logic);
            if (c == CHK) check_outputs(tag);
        end
    endtask

    task automatic do_enable(input string tag);
        enable = 1'b1;
        model_enable();
        repeat (2) @(negedge clk_logic);
        check_outputs(tag);
    endtask

    task automatic do_disable(input string tag);
        enable = 1'b0;
        model_disable();
        repeat (3) @(negedge clk_logic);
        check_outputs(tag);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int waited;
        default_period = 24'd777;
        delay_comp     = 16'd10;

        // Reset state.
        repeat (2) @(negedge clk_logic);
        check("reset.period", 64'(period), 64'd0);
        check("reset.phase", 64'(phase_shift), 64'd0);
        check("reset.latch", 64'(latch), 64'd0);
        check("reset.locked", 64'(locked), 64'd0);
        check("reset.fault", 64'(fault), 64'd0);
        reset_n = 1'b1;
        model_disable();
        repeat (3) @(negedge clk_logic);
        check_outputs("idle");

        // Open loop, no edges: defaults latched, then timeout fault.
        do_enable("enable");
        check("enable.period_const", 64'(period), 64'd777);
        check("enable.phase_const", 64'(phase_shift), 64'd184);
        waited = 2;
        while (fault !== 1'b1 && waited < TIMEOUT_CNT + 100) begin
            @(negedge clk_logic);
            waited++;
        end
        check("fault.timing", 64'(waited >= TIMEOUT_CNT && waited <= TIMEOUT_CNT + 4), 64'd1);
        m_mode  = M_FAULT;
        m_fault = 1'b1;
        model_defaults();
        m_lat_pend++;
        @(negedge clk_logic);
        check_outputs("fault");
        pulse("fault_edge", 100, 100);
        do_disable("fault_clear");

        // 200-cycle square wave: lock on the 5th edge.
        do_enable("sq_en");
        for (int i = 0; i < 8; i++) pulse("sq", 100, 100);
        check("sq.period_const", 64'(period), 64'd800);
        check("sq.phase_const", 64'(phase_shift), 64'd190);

        // Comparator glitch shortly after a true edge.
        pulse("pre_glitch", 6, 3);
        pulse("glitch", 91, 100);
        pulse("post_glitch", 100, 100);
        check("glitch.period_const", 64'(period), 64'd800);

        // Edges stop for 5000 cycles, then resume: drop to ACQUIRE, relock.
        pulse("gap", 100, 5000);
        for (int i = 0; i < 6; i++) pulse("relock", 100, 100);

        // Interval boundaries while tracking: 16, 15 (glitch), 4096, 4097.
        pulse("b16a", 8, 8);
        pulse("b16b", 8, 7);
        pulse("b15", 100, 100);
        pulse("b4096a", 2048, 2048);
        pulse("b4096b", 2048, 2049);
        for (int i = 0; i < 6; i++) pulse("b4097", 100, 100);

        // Asynchronous reset mid-TRACK.
        @(negedge clk_logic);
        #2 reset_n = 1'b0;
        #1;
        check("midrst.period", 64'(period), 64'd0);
        check("midrst.phase", 64'(phase_shift), 64'd0);
        check("midrst.latch", 64'(latch), 64'd0);
        check("midrst.locked", 64'(locked), 64'd0);
        check("midrst.fault", 64'(fault), 64'd0);
        repeat (2) @(negedge clk_logic);
        lat_seen   = lat_cnt;
        m_lat_pend = 0;
        reset_n    = 1'b1;
        model_enable();
        repeat (2) @(negedge clk_logic);
        check_outputs("rst_release");
        for (int i = 0; i < 6; i++) pulse("reacq", 100, 100);

        // Randomised sessions.
        for (int s = 0; s < 6; s++) begin
            enable         = 1'b0;
            default_period = 24'($urandom);
            delay_comp     = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                         : 16'($urandom_range(0, 60));
            do_disable("rnd_idle");
            do_enable("rnd_en");
            for (int k = 0; k < 20; k++) begin
                int kind, n;
                kind = $urandom_range(0, 19);
                if (kind == 0)      n = $urandom_range(4090, 4110);
                else if (kind < 3)  n = $urandom_range(6, 20);
                else                n = $urandom_range(MIN_CNT, 300);
                pulse("rnd", n / 2, n - n / 2);
            end
        end
        do_disable("end_idle");

        check("latch_back_to_back", 64'(dbl), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
